// File: rtl/ase_c1_write_responder.sv
// rtl/ase_c1_write_responder.sv - CCI-P C1 write/fence responder with in-order latency-gated response FIFO
module ase_c1_write_responder #(
    parameter int FIFO_DEPTH_BASE2 = 5,
    parameter int RESP_LATENCY     = 8,
    parameter int ALMFULL_MARGIN   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         c1tx_valid,
    input  logic [73:0]  c1tx_hdr,
    input  logic [511:0] c1tx_data,
    output logic         c1tx_almfull,
    input  logic         c1rx_stall,
    output logic         wr_mem_valid,
    output logic [41:0]  wr_mem_addr,
    output logic [511:0] wr_mem_data,
    output logic         c1rx_valid,
    output logic [27:0]  c1rx_hdr,
    output logic         err_protocol
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BASE2;
    localparam int PTR_W = FIFO_DEPTH_BASE2;
    localparam int CNT_W = FIFO_DEPTH_BASE2 + 1;
    localparam logic [7:0] LAT = 8'(RESP_LATENCY);
    localparam logic [CNT_W-1:0] ALMFULL_TH = CNT_W'(DEPTH - ALMFULL_MARGIN);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [3:0] RT_WRLINE_I  = 4'd3;
    localparam logic [3:0] RT_WRLINE_M  = 4'd4;
    localparam logic [3:0] RT_WRFENCE   = 4'd5;
    localparam logic [3:0] RT_WR_RSP    = 4'd2;
    localparam logic [3:0] RT_FENCE_RSP = 4'd4;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MULTI = 1'b1;

    logic [1:0]  tx_vc, tx_len;
    logic        tx_sop;
    logic [3:0]  tx_rt;
    logic [41:0] tx_addr;
    logic [15:0] tx_mdata;
    logic        unused_hdr_bits;

    assign tx_vc    = c1tx_hdr[73:72];
    assign tx_sop   = c1tx_hdr[71];
    assign tx_len   = c1tx_hdr[69:68];
    assign tx_rt    = c1tx_hdr[67:64];
    assign tx_addr  = c1tx_hdr[57:16];
    assign tx_mdata = c1tx_hdr[15:0];
    assign unused_hdr_bits = ^{c1tx_hdr[70], c1tx_hdr[63:58]};

    logic [0:0]  state_q, state_d;
    logic [1:0]  beat_q, beat_d, len_q, len_d, vc_q, vc_d;
    logic [41:0] base_q, base_d;
    logic [15:0] mdata_q, mdata_d;
    logic        wr_valid_q, rx_valid_q, almfull_q, err_q;
    logic [41:0] wr_addr_q;
    logic [511:0] wr_data_q;
    logic [27:0] rx_hdr_q;
    logic [7:0]  ts_q;

    logic [27:0] hdr_mem [DEPTH];
    logic [7:0]  ts_mem  [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] ripe_q, ripe_d;

    logic        is_write, is_fence, misaligned;
    logic        push, do_push, pop, wr_fire, err_set;
    logic [27:0] push_hdr;
    logic [41:0] wr_addr_n;
    logic [7:0]  head_age;

    function automatic logic [27:0] mk_rsp(input logic [1:0] vc, input logic [1:0] len,
                                           input logic [3:0] rt, input logic [15:0] md);
        logic [1:0] vu;
        vu = (vc == 2'd0) ? 2'd1 : vc;
        return {vu, 1'b0, 1'b0, (len != 2'd0), 1'b0, len, rt, md};
    endfunction

    assign is_write   = (tx_rt == RT_WRLINE_I) || (tx_rt == RT_WRLINE_M);
    assign is_fence   = (tx_rt == RT_WRFENCE);
    assign misaligned = ((tx_len == 2'd1) && tx_addr[0]) || ((tx_len == 2'd3) && (tx_addr[1:0] != 2'd0));

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        len_d     = len_q;
        mdata_d   = mdata_q;
        vc_d      = vc_q;
        push      = 1'b0;
        push_hdr  = '0;
        wr_fire   = 1'b0;
        wr_addr_n = '0;
        err_set   = 1'b0;
        if (c1tx_valid) begin
            if (!is_write && !is_fence) begin
                err_set = 1'b1;
            end else if (state_q == ST_MULTI && is_write && !tx_sop) begin
                // Continuation beats take their address from the packet base, not the header
                wr_fire   = 1'b1;
                wr_addr_n = base_q + {40'd0, beat_q};
                if (beat_q == len_q) begin
                    push     = 1'b1;
                    push_hdr = mk_rsp(vc_q, len_q, RT_WR_RSP, mdata_q);
                    state_d  = ST_IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end else begin
                if (state_q == ST_MULTI) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end
                if (is_fence) begin
                    if (state_q == ST_IDLE) begin
                        push     = 1'b1;
                        push_hdr = mk_rsp(tx_vc, 2'd0, RT_FENCE_RSP, tx_mdata);
                    end
                end else if (!tx_sop || (tx_len == 2'd2) || misaligned) begin
                    err_set = 1'b1;
                end else begin
                    wr_fire   = 1'b1;
                    wr_addr_n = tx_addr;
                    if (tx_len == 2'd0) begin
                        push     = 1'b1;
                        push_hdr = mk_rsp(tx_vc, 2'd0, RT_WR_RSP, tx_mdata);
                    end else begin
                        state_d = ST_MULTI;
                        beat_d  = 2'd1;
                        base_d  = tx_addr;
                        len_d   = tx_len;
                        mdata_d = tx_mdata;
                        vc_d    = tx_vc;
                    end
                end
            end
        end
    end

    // Ripe bits latch once an entry has aged enough, so a long stall cannot wrap its age back below the latency
    always_comb begin
        head_age = ts_q - ts_mem[rd_q];
        do_push  = push && (count_q != FULL_CNT);
        pop      = (count_q != '0) && !c1rx_stall && (ripe_q[rd_q] || (head_age >= LAT));
        case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ripe_d = ripe_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (wr_q == PTR_W'(i))) begin
                ripe_d[i] = 1'b0;
            end else if (8'(ts_q - ts_mem[i]) >= LAT) begin
                ripe_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            hdr_mem[wr_q] <= push_hdr;
            ts_mem[wr_q]  <= ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            mdata_q    <= '0;
            vc_q       <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_hdr_q   <= '0;
            almfull_q  <= 1'b0;
            err_q      <= 1'b0;
            ts_q       <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            ripe_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            len_q      <= len_d;
            mdata_q    <= mdata_d;
            vc_q       <= vc_d;
            wr_valid_q <= wr_fire;
            wr_addr_q  <= wr_fire ? wr_addr_n : '0;
            wr_data_q  <= wr_fire ? c1tx_data : '0;
            rx_valid_q <= pop;
            rx_hdr_q   <= pop ? hdr_mem[rd_q] : '0;
            almfull_q  <= (count_d >= ALMFULL_TH);
            err_q      <= err_q | err_set | (push && !do_push);
            ts_q       <= ts_q + 8'd1;
            rd_q       <= pop ? rd_q + PTR_W'(1) : rd_q;
            wr_q       <= do_push ? wr_q + PTR_W'(1) : wr_q;
            count_q    <= count_d;
            ripe_q     <= ripe_d;
        end
    end

    assign c1tx_almfull = almfull_q;
    assign wr_mem_valid = wr_valid_q;
    assign wr_mem_addr  = wr_addr_q;
    assign wr_mem_data  = wr_data_q;
    assign c1rx_valid   = rx_valid_q;
    assign c1rx_hdr     = rx_hdr_q;
    assign err_protocol = err_q;
endmodule

// File: tb/tb_ase_c1_write_responder.sv
// tb/tb_ase_c1_write_responder.sv - vector table plus scoreboard bench for ase_c1_write_responder
module tb_ase_c1_write_responder;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         c1tx_valid = 1'b0;
    logic [73:0]  c1tx_hdr = '0;
    logic [511:0] c1tx_data = '0;
    logic         c1tx_almfull;
    logic         c1rx_stall = 1'b0;
    logic         wr_mem_valid;
    logic [41:0]  wr_mem_addr;
    logic [511:0] wr_mem_data;
    logic         c1rx_valid;
    logic [27:0]  c1rx_hdr;
    logic         err_protocol;

    ase_c1_write_responder #(.FIFO_DEPTH_BASE2(5), .RESP_LATENCY(L), .ALMFULL_MARGIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .c1tx_valid(c1tx_valid), .c1tx_hdr(c1tx_hdr),
        .c1tx_data(c1tx_data), .c1tx_almfull(c1tx_almfull), .c1rx_stall(c1rx_stall),
        .wr_mem_valid(wr_mem_valid), .wr_mem_addr(wr_mem_addr), .wr_mem_data(wr_mem_data),
        .c1rx_valid(c1rx_valid), .c1rx_hdr(c1rx_hdr), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [41:0]  addr;
        logic [511:0] data;
    } mem_t;
    typedef struct {
        logic [27:0] hdr;
        int          due;
    } rsp_t;
    typedef struct {
        bit          v;
        logic [1:0]  vc;
        bit          sop;
        logic [1:0]  len;
        logic [3:0]  rt;
        logic [41:0] addr;
        logic [15:0] mdata;
        bit          exp_mem;
        logic [41:0] exp_addr;
        bit          exp_rsp;
        logic [27:0] exp_hdr;
    } vec_t;

    mem_t mem_q[$];
    rsp_t rsp_q[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [73:0] tx(input logic [1:0] vc, input bit sop, input logic [1:0] len,
                                       input logic [3:0] rt, input logic [41:0] addr, input logic [15:0] md);
        logic [73:0] h;
        h = '0;
        h[73:72] = vc;
        h[71]    = sop;
        h[69:68] = len;
        h[67:64] = rt;
        h[57:16] = addr;
        h[15:0]  = md;
        return h;
    endfunction

    function automatic logic [27:0] rsp(input logic [1:0] vu, input bit fmt, input logic [1:0] cl,
                                        input logic [3:0] rt, input logic [15:0] md);
        return {vu, 2'b00, fmt, 1'b0, cl, rt, md};
    endfunction

    task automatic beat(input bit v, input logic [73:0] h, input logic [511:0] d, input bit em,
                        input logic [41:0] ea, input bit er, input logic [27:0] eh, input bit timed);
        int e;
        e = cyc;
        c1tx_valid = v;
        c1tx_hdr   = h;
        c1tx_data  = d;
        if (em) mem_q.push_back('{ea, d});
        if (er) rsp_q.push_back('{eh, timed ? e + L + 1 : -1});
        @(posedge clk);
        #2;
        c1tx_valid = 1'b0;
    endtask

    task automatic wr1(input logic [41:0] a, input logic [15:0] md, input bit er, input bit timed);
        beat(1'b1, tx(2'd1, 1'b1, 2'd0, 4'd3, a, md), {16{32'hA000_0000 | 32'(a)}}, 1'b1, a, er,
             rsp(2'd1, 1'b0, 2'd0, 4'd2, md), timed);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_valid"}, wr_mem_valid, 0);
        check({tag, "_wr_addr"}, wr_mem_addr, 0);
        check({tag, "_rx_valid"}, c1rx_valid, 0);
        check({tag, "_rx_hdr"}, c1rx_hdr, 0);
        check({tag, "_almfull"}, c1tx_almfull, 0);
        check({tag, "_err"}, err_protocol, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c1tx_valid = 1'b0;
        c1rx_stall = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mem_q.delete();
        rsp_q.delete();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mem_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_outstanding", mem_q.size() + rsp_q.size(), 0);
        mem_q.delete();
        rsp_q.delete();
        repeat (12) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_mem_valid) begin
                if (mem_q.size() == 0) check("unexpected_mem_write", wr_mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    mem_t m;
                    m = mem_q.pop_front();
                    check("mem_addr", wr_mem_addr, m.addr);
                    check("mem_data_match", (wr_mem_data == m.data), 1);
                end
            end
            if (c1rx_valid) begin
                if (rsp_q.size() == 0) check("unexpected_rsp", c1rx_hdr, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_hdr", c1rx_hdr, r.hdr);
                    if (r.due >= 0) check("rsp_cycle", cyc, r.due);
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].due >= 0 && cyc > rsp_q[0].due) begin
                check("rsp_missing_at_cycle", cyc, rsp_q[0].due);
                void'(rsp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vt[13];
    logic [73:0] errs[5];

    initial begin
        vt[0]  = '{1'b1, 2'd0, 1'b1, 2'd0, 4'd3, 42'h100, 16'h1234, 1'b1, 42'h100, 1'b1, rsp(2'd1, 1'b0, 2'd0, 4'd2, 16'h1234)};
        vt[1]  = '{1'b1, 2'd2, 1'b1, 2'd3, 4'd3, 42'h200, 16'h00A5, 1'b1, 42'h200, 1'b0, 28'h0};
        vt[2]  = '{1'b1, 2'd1, 1'b0, 2'd3, 4'd3, 42'h3FF, 16'hBEEF, 1'b1, 42'h201, 1'b0, 28'h0};
        vt[3]  = '{1'b1, 2'd3, 1'b0, 2'd3, 4'd4, 42'h777, 16'h5555, 1'b1, 42'h202, 1'b0, 28'h0};
        vt[4]  = '{1'b1, 2'd0, 1'b0, 2'd3, 4'd3, 42'h123, 16'h9999, 1'b1, 42'h203, 1'b1, rsp(2'd2, 1'b1, 2'd3, 4'd2, 16'h00A5)};
        vt[5]  = '{1'b1, 2'd3, 1'b1, 2'd1, 4'd4, 42'h300, 16'h0011, 1'b1, 42'h300, 1'b0, 28'h0};
        vt[6]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 42'h0,   16'h0,    1'b0, 42'h0,   1'b0, 28'h0};
        vt[7]  = '{1'b1, 2'd1, 1'b0, 2'd1, 4'd4, 42'hABC, 16'hFFFF, 1'b1, 42'h301, 1'b1, rsp(2'd3, 1'b1, 2'd1, 4'd2, 16'h0011)};
        vt[8]  = '{1'b1, 2'd1, 1'b1, 2'd0, 4'd3, 42'h010, 16'h0001, 1'b1, 42'h010, 1'b1, rsp(2'd1, 1'b0, 2'd0, 4'd2, 16'h0001)};
        vt[9]  = '{1'b1, 2'd1, 1'b1, 2'd0, 4'd3, 42'h011, 16'h0002, 1'b1, 42'h011, 1'b1, rsp(2'd1, 1'b0, 2'd0, 4'd2, 16'h0002)};
        vt[10] = '{1'b1, 2'd1, 1'b1, 2'd0, 4'd4, 42'h012, 16'h0003, 1'b1, 42'h012, 1'b1, rsp(2'd1, 1'b0, 2'd0, 4'd2, 16'h0003)};
        vt[11] = '{1'b1, 2'd0, 1'b1, 2'd0, 4'd5, 42'h0,   16'h0007, 1'b0, 42'h0,   1'b1, rsp(2'd1, 1'b0, 2'd0, 4'd4, 16'h0007)};
        vt[12] = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 42'h0,   16'h0,    1'b0, 42'h0,   1'b0, 28'h0};

        errs[0] = tx(2'd1, 1'b1, 2'd2, 4'd3, 42'h100, 16'h0E01);
        errs[1] = tx(2'd1, 1'b1, 2'd0, 4'd1, 42'h100, 16'h0E02);
        errs[2] = tx(2'd1, 1'b1, 2'd1, 4'd3, 42'h101, 16'h0E03);
        errs[3] = tx(2'd1, 1'b1, 2'd3, 4'd3, 42'h102, 16'h0E04);
        errs[4] = tx(2'd1, 1'b0, 2'd0, 4'd3, 42'h100, 16'h0E05);

        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < 13; i++) begin
            beat(vt[i].v, tx(vt[i].vc, vt[i].sop, vt[i].len, vt[i].rt, vt[i].addr, vt[i].mdata),
                 {16{32'hC0DE_0000 + 32'(i)}}, vt[i].exp_mem, vt[i].exp_addr, vt[i].exp_rsp, vt[i].exp_hdr, 1'b1);
        end
        drain(60);
        check("table_err", err_protocol, 0);
        check("table_almfull", c1tx_almfull, 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            check("err_before", err_protocol, 0);
            beat(1'b1, errs[i], {16{32'hBAD0_0000 + 32'(i)}}, 1'b0, 42'h0, 1'b0, 28'h0, 1'b0);
            check("err_set", err_protocol, 1);
            check("err_no_write", wr_mem_valid, 0);
            drain(4);
        end

        do_reset();
        beat(1'b1, tx(2'd1, 1'b1, 2'd3, 4'd3, 42'h400, 16'h0044), {16{32'h4444_4444}}, 1'b1, 42'h400, 1'b0, 28'h0, 1'b0);
        wr1(42'h500, 16'h0055, 1'b1, 1'b1);
        check("sop_in_multi_err", err_protocol, 1);
        drain(20);

        do_reset();
        beat(1'b1, tx(2'd1, 1'b1, 2'd1, 4'd3, 42'h700, 16'h0077), {16{32'h7777_7777}}, 1'b1, 42'h700, 1'b0, 28'h0, 1'b0);
        beat(1'b1, tx(2'd1, 1'b1, 2'd0, 4'd5, 42'h0, 16'h0009), '0, 1'b0, 42'h0, 1'b0, 28'h0, 1'b0);
        check("fence_in_multi_err", err_protocol, 1);
        drain(20);

        do_reset();
        c1rx_stall = 1'b1;
        for (int i = 0; i < 33; i++) begin
            wr1(42'h1000 + 42'(i), 16'(i), (i < 32), 1'b0);
            if (i == 26) check("almfull_at_27", c1tx_almfull, 0);
            if (i == 27) check("almfull_at_28", c1tx_almfull, 1);
            if (i == 31) check("err_at_full", err_protocol, 0);
            if (i == 32) check("err_after_drop", err_protocol, 1);
        end
        repeat (12) @(posedge clk);
        #2;
        begin
            int r;
            r = cyc;
            for (int k = 0; k < rsp_q.size(); k++) rsp_q[k].due = r + 1 + k;
            c1rx_stall = 1'b0;
            for (int k = 0; k < 7; k++) begin
                @(posedge clk);
                #2;
                check("almfull_draining", c1tx_almfull, ((31 - k) >= 28) ? 1 : 0);
            end
        end
        drain(60);

        do_reset();
        beat(1'b1, tx(2'd1, 1'b1, 2'd3, 4'd3, 42'h600, 16'h0066), {16{32'h6666_0001}}, 1'b1, 42'h600, 1'b0, 28'h0, 1'b0);
        beat(1'b1, tx(2'd1, 1'b0, 2'd3, 4'd3, 42'h0, 16'h0), {16{32'h6666_0002}}, 1'b0, 42'h0, 1'b0, 28'h0, 1'b0);
        check("pre_reset_wr_valid", wr_mem_valid, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midpkt_reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mem_q.delete();
        rsp_q.delete();
        @(posedge clk);
        #2;
        wr1(42'h40, 16'h0040, 1'b1, 1'b1);
        drain(20);
        check("post_reset_err", err_protocol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
